// File: rtl/simon_host_pkg.sv
// Shared defaults and FSM state types for the SIMON packet host.
// Optional cycle counter is enabled with SIMON_HOST_CYCLE_CNT_EN.
package simon_host_pkg;

  localparam int PKT_BYTES_DEF = 66;
  localparam int HS_GAP_DEF    = 2;
  localparam int READ_HOLD_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PRESENT,
    HOLD,
    WAITDONE,
    GAP
  } tx_state_t;

  typedef enum logic [1:0] {
    RIDLE,
    RDELAY,
    READ
  } rx_state_t;

endpackage

// File: rtl/simon_host_edge.sv
// Registers one handshake input and flags rising edges of the
// registered copy.
module simon_host_edge (
  input  logic clk,
  input  logic nR,
  input  logic d,
  output logic rise
);

  logic sig_q, sig_d;
  logic prev_q, prev_d;

  always_comb begin
    sig_d  = d;
    prev_d = sig_q;
  end

  always_ff @(posedge clk) begin
    if (!nR) begin
      sig_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sig_q  <= sig_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sig_q & ~prev_q;

endmodule

// File: rtl/simon_pkt_host.sv
// Host that streams packets from a store into the SIMON core and
// collects results. SIMON_HOST_CYCLE_CNT_EN builds the run cycle counter.
module simon_pkt_host
  import simon_host_pkg::*;
#(
  parameter int PKT_BYTES = PKT_BYTES_DEF,
  parameter int HS_GAP    = HS_GAP_DEF,
  parameter int READ_HOLD = READ_HOLD_DEF
) (
  input  logic                   clk,
  input  logic                   nR,
  input  logic                   start,
  input  logic [15:0]            pkt_count,
  output logic [15:0]            src_addr,
  input  logic [PKT_BYTES*8-1:0] src_data,
  output logic                   in_newPKT,
  input  logic                   in_loadPKT,
  input  logic                   in_donePKT,
  output logic [PKT_BYTES*8-1:0] in,
  input  logic                   out_donePKT,
  output logic                   out_readPKT,
  input  logic [PKT_BYTES*8-1:0] out,
  output logic                   sink_valid,
  output logic [PKT_BYTES*8-1:0] sink_data,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output logic [31:0]            cycle_count
);

  localparam int W = PKT_BYTES*8;
  localparam logic [7:0] GAP_LAST  = 8'(HS_GAP-1);
  localparam logic [7:0] HOLD_LAST = 8'(READ_HOLD-1);

  logic load_rise, tdone_rise, odone_rise;

  simon_host_edge u_load (
    .clk (clk), .nR (nR), .d (in_loadPKT), .rise (load_rise)
  );
  simon_host_edge u_tdone (
    .clk (clk), .nR (nR), .d (in_donePKT), .rise (tdone_rise)
  );
  simon_host_edge u_odone (
    .clk (clk), .nR (nR), .d (out_donePKT), .rise (odone_rise)
  );

  tx_state_t    tx_q, tx_d;
  logic [7:0]   tcnt_q, tcnt_d;
  logic [15:0]  pkt_q, pkt_d;
  logic [15:0]  tx_idx_q, tx_idx_d;
  logic [15:0]  addr_q, addr_d;
  logic [W-1:0] in_q, in_d;
  logic         new_q, new_d;
  logic         tx_fin_q, tx_fin_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  rx_state_t    rx_q, rx_d;
  logic [7:0]   rcnt_q, rcnt_d;
  logic [15:0]  rx_idx_q, rx_idx_d;
  logic         pend_q, pend_d;
  logic         ovr_q, ovr_d;
  logic         read_q, read_d;
  logic         sv_q, sv_d;
  logic [W-1:0] sink_q, sink_d;

  logic go, ev;
  assign go = start & ~busy_q;
  // Result edges outside a run are not ours to collect.
  assign ev = odone_rise & busy_q;

  always_comb begin
    tx_d     = tx_q;
    tcnt_d   = tcnt_q;
    pkt_d    = pkt_q;
    tx_idx_d = tx_idx_q;
    addr_d   = addr_q;
    in_d     = in_q;
    new_d    = new_q;
    tx_fin_d = tx_fin_q;
    busy_d   = busy_q;
    done_d   = done_q;
    unique case (tx_q)
      IDLE: begin
        if (go) begin
          pkt_d    = pkt_count;
          tx_idx_d = '0;
          tx_fin_d = 1'b0;
          done_d   = (pkt_count == 16'd0);
          busy_d   = (pkt_count != 16'd0);
          if (pkt_count != 16'd0) begin
            tx_d   = FETCH;
            tcnt_d = '0;
            addr_d = '0;
          end
        end
      end
      FETCH: begin
        if (tcnt_q == 8'd1) begin
          in_d  = src_data;
          new_d = 1'b1;
          tx_d  = PRESENT;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      PRESENT: begin
        if (load_rise) begin
          tx_d   = HOLD;
          tcnt_d = '0;
        end
      end
      HOLD: begin
        if (tcnt_q == GAP_LAST) begin
          new_d    = 1'b0;
          tx_idx_d = tx_idx_q + 16'd1;
          tx_d     = WAITDONE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      WAITDONE: begin
        if (tdone_rise) begin
          if (tx_idx_q < pkt_q) begin
            tx_d   = GAP;
            tcnt_d = '0;
          end else begin
            tx_d     = IDLE;
            tx_fin_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (tcnt_q == GAP_LAST) begin
          tx_d   = FETCH;
          tcnt_d = '0;
          addr_d = tx_idx_q;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      default: tx_d = IDLE;
    endcase
    if (busy_q && tx_fin_q && rx_idx_q == pkt_q) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_comb begin
    rx_d     = rx_q;
    rcnt_d   = rcnt_q;
    rx_idx_d = rx_idx_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    read_d   = read_q;
    sv_d     = 1'b0;
    sink_d   = sink_q;
    if (go) begin
      rx_idx_d = '0;
      ovr_d    = 1'b0;
      pend_d   = 1'b0;
    end
    unique case (rx_q)
      RIDLE: begin
        if (pend_q || ev) begin
          rx_d   = RDELAY;
          rcnt_d = '0;
          // Serving the pending edge while a new one lands re-arms it.
          pend_d = pend_q & ev;
        end
      end
      RDELAY: begin
        if (rcnt_q == GAP_LAST) begin
          rx_d   = READ;
          rcnt_d = '0;
          read_d = 1'b1;
          sv_d   = 1'b1;
          sink_d = out;
        end else begin
          rcnt_d = rcnt_q + 8'd1;
        end
      end
      READ: begin
        if (rcnt_q == HOLD_LAST) begin
          rx_d     = RIDLE;
          read_d   = 1'b0;
          rx_idx_d = rx_idx_q + 16'd1;
        end else begin
          rcnt_d = rcnt_q + 8'd1;
        end
      end
      default: rx_d = RIDLE;
    endcase
    if (ev && rx_q != RIDLE) begin
      if (pend_q) ovr_d  = 1'b1;
      else        pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nR) begin
      tx_q     <= IDLE;
      tcnt_q   <= '0;
      pkt_q    <= '0;
      tx_idx_q <= '0;
      addr_q   <= '0;
      in_q     <= '0;
      new_q    <= 1'b0;
      tx_fin_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rx_q     <= RIDLE;
      rcnt_q   <= '0;
      rx_idx_q <= '0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      read_q   <= 1'b0;
      sv_q     <= 1'b0;
      sink_q   <= '0;
    end else begin
      tx_q     <= tx_d;
      tcnt_q   <= tcnt_d;
      pkt_q    <= pkt_d;
      tx_idx_q <= tx_idx_d;
      addr_q   <= addr_d;
      in_q     <= in_d;
      new_q    <= new_d;
      tx_fin_q <= tx_fin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rx_q     <= rx_d;
      rcnt_q   <= rcnt_d;
      rx_idx_q <= rx_idx_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      read_q   <= read_d;
      sv_q     <= sv_d;
      sink_q   <= sink_d;
    end
  end

`ifdef SIMON_HOST_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (go)          cyc_d = '0;
    else if (busy_q) cyc_d = cyc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!nR) cyc_q <= '0;
    else     cyc_q <= cyc_d;
  end

  assign cycle_count = cyc_q;
`else
  assign cycle_count = '0;
`endif

  assign src_addr    = addr_q;
  assign in          = in_q;
  assign in_newPKT   = new_q;
  assign out_readPKT = read_q;
  assign sink_valid  = sv_q;
  assign sink_data   = sink_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_simon_pkt_host.sv
// Directed bench for simon_pkt_host: core responder, packet store
// model and result scoreboard.
module tb_simon_pkt_host;
  import simon_host_pkg::*;

  localparam int W = PKT_BYTES_DEF*8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         nR, start;
  logic [15:0]  pkt_count, src_addr;
  logic [W-1:0] src_data, in, out, sink_data;
  logic         in_newPKT, in_loadPKT, in_donePKT;
  logic         out_donePKT, out_readPKT, sink_valid;
  logic         busy, done, overrun;
  logic [31:0]  cycle_count;

  simon_pkt_host dut (
    .clk         (clk),
    .nR          (nR),
    .start       (start),
    .pkt_count   (pkt_count),
    .src_addr    (src_addr),
    .src_data    (src_data),
    .in_newPKT   (in_newPKT),
    .in_loadPKT  (in_loadPKT),
    .in_donePKT  (in_donePKT),
    .in          (in),
    .out_donePKT (out_donePKT),
    .out_readPKT (out_readPKT),
    .out         (out),
    .sink_valid  (sink_valid),
    .sink_data   (sink_data),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .cycle_count (cycle_count)
  );

  typedef struct {
    int           due;
    logic [W-1:0] data;
  } res_t;

  typedef struct {
    int pc;
    int ld;
    int dd;
    int rd;
    bit ares;
    int pre;
    int exp_sinks;
    bit exp_ovr;
  } run_t;

  res_t rq[$];
  int ld = 1, dd = 1, rd = 3;
  bit auto_res = 1'b1;
  bit fix_en = 1'b0;
  logic [W-1:0] fix_data = '0;
  int checks = 0, errors = 0;
  int tx_exp = 0, rx_exp = 0, sinks = 0, new_rises = 0;
  logic new_prev = 1'b0;
  int tb_cyc = 0;

  function automatic logic [W-1:0] g(input logic [15:0] a);
    return {{16{a, ~a}}, a ^ 16'h5a5a};
  endfunction

  function automatic logic [W-1:0] f(input logic [W-1:0] p);
    return ~{p[7:0], p[W-1:8]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic chkw(input string nm, input logic [W-1:0] a,
                      input logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, a, e);
    end
  endtask

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  // Packet store: registered read, data one cycle after address.
  always @(posedge clk) src_data <= g(src_addr);

  // Core responder: load, then done once the offer is withdrawn.
  initial begin
    in_loadPKT = 1'b0;
    in_donePKT = 1'b0;
    forever begin
      @(negedge clk);
      if (in_newPKT) begin
        for (int i = 1; i < ld; i++) @(negedge clk);
        in_loadPKT = 1'b1;
        if (auto_res) rq.push_back('{due: tb_cyc + rd, data: f(in)});
        @(negedge clk);
        in_loadPKT = 1'b0;
        while (in_newPKT) @(negedge clk);
        for (int i = 1; i < dd; i++) @(negedge clk);
        in_donePKT = 1'b1;
        @(negedge clk);
        in_donePKT = 1'b0;
      end
    end
  end

  // Result channel: one pulse per queued result, low cycle between.
  initial begin
    out = '0;
    out_donePKT = 1'b0;
    forever begin
      @(negedge clk);
      if (out_donePKT) begin
        out_donePKT = 1'b0;
      end else if (rq.size() > 0 && tb_cyc >= rq[0].due) begin
        out = rq[0].data;
        out_donePKT = 1'b1;
        void'(rq.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (in_newPKT && !new_prev) begin
        new_rises++;
        chk("src_addr", 64'(src_addr), 64'(tx_exp));
        chkw("in_pkt", in, g(16'(tx_exp)));
        tx_exp++;
      end
      new_prev = in_newPKT;
      if (sink_valid) begin
        chkw("sink_data", sink_data,
             fix_en ? fix_data : f(g(16'(rx_exp))));
        rx_exp++;
        sinks++;
      end
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_new"}, 64'(in_newPKT), 64'd0);
    chk({tag, "_read"}, 64'(out_readPKT), 64'd0);
    chk({tag, "_sv"}, 64'(sink_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_ovr"}, 64'(overrun), 64'd0);
    chk({tag, "_addr"}, 64'(src_addr), 64'd0);
    chk({tag, "_cyc"}, 64'(cycle_count), 64'd0);
    chkw({tag, "_in"}, in, '0);
    chkw({tag, "_sink"}, sink_data, '0);
  endtask

  task automatic clear_counts();
    tx_exp = 0;
    rx_exp = 0;
    sinks = 0;
    new_rises = 0;
  endtask

  task automatic start_pulse(input int pc);
    pkt_count = 16'(pc);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      @(posedge clk);
      n++;
      #1;
    end
  endtask

  task automatic do_run(input run_t r);
    int n;
    ld = r.ld;
    dd = r.dd;
    rd = r.rd;
    auto_res = r.ares;
    fix_en = (r.pre != 0);
    fix_data = f(g(16'd0));
    clear_counts();
    @(negedge clk);
    if (r.pre == 1) begin
      rq.push_back('{due: tb_cyc + 6, data: fix_data});
      rq.push_back('{due: tb_cyc + 9, data: fix_data});
    end else if (r.pre == 2) begin
      rq.push_back('{due: tb_cyc + 6, data: fix_data});
      rq.push_back('{due: tb_cyc + 8, data: fix_data});
      rq.push_back('{due: tb_cyc + 10, data: fix_data});
    end
    start_pulse(r.pc);
    wait_done(r.pc * 40 + 300, n);
    chk("run_done", 64'(done), 64'd1);
    chk("run_busy", 64'(busy), 64'd0);
    chk("run_ovr", 64'(overrun), 64'(r.exp_ovr));
    chk("run_sinks", 64'(sinks), 64'(r.exp_sinks));
    chk("run_tx", 64'(new_rises), 64'(r.pc));
`ifdef SIMON_HOST_CYCLE_CNT_EN
    chk("run_cycles", 64'(cycle_count), 64'(n));
`else
    chk("run_cycles", 64'(cycle_count), 64'd0);
`endif
    repeat (5) @(negedge clk);
  endtask

  initial begin
    run_t runs[6];
    int n, nr0;
    runs[0] = '{1, 3, 5, 10, 1'b1, 0, 1, 1'b0};
    runs[1] = '{3, 1, 1, 2, 1'b1, 0, 3, 1'b0};
    runs[2] = '{5, 2, 3, 15, 1'b1, 0, 5, 1'b0};
    runs[3] = '{2, 1, 2, 0, 1'b0, 1, 2, 1'b0};
    runs[4] = '{2, 1, 2, 0, 1'b0, 2, 2, 1'b1};
    runs[5] = '{2402, 1, 1, 3, 1'b1, 0, 2402, 1'b0};

    nR = 1'b0;
    start = 1'b0;
    pkt_count = '0;
    repeat (3) @(negedge clk);
    chk_idle("rst");
    nR = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) do_run(runs[i]);

    // Empty run completes on the start edge with no core traffic.
    clear_counts();
    @(negedge clk);
    start_pulse(0);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    chk("zero_cyc", 64'(cycle_count), 64'd0);
    repeat (10) @(negedge clk);
    chk("zero_new", 64'(new_rises), 64'd0);

    // A start during a run must not change its packet count.
    ld = 1; dd = 1; rd = 3;
    auto_res = 1'b1;
    fix_en = 1'b0;
    clear_counts();
    @(negedge clk);
    start_pulse(2);
    repeat (8) @(negedge clk);
    start_pulse(9);
    wait_done(400, n);
    chk("busy_start_done", 64'(done), 64'd1);
    chk("busy_start_sinks", 64'(sinks), 64'd2);
    chk("busy_start_tx", 64'(new_rises), 64'd2);
    repeat (5) @(negedge clk);

    // Reset in the middle of a run.
    clear_counts();
    @(negedge clk);
    start_pulse(5);
    n = 0;
    while (!in_newPKT && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_new_seen", 64'(in_newPKT), 64'd1);
    @(negedge clk);
    nR = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_idle("midrst");
    nR = 1'b1;
    nr0 = new_rises;
    repeat (20) @(negedge clk);
    chk("mid_no_new", 64'(new_rises), 64'(nr0));
    chk("mid_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
